// File: rtl/ex_stage_pipe.sv
// ----------------------------------------------------------------------------
// ex_stage_pipe -- registered execute stage of the pipelined MIPS core.
//
// This stage does three things:
//   * Picks ALU operand B: the register operand or the sign-extended immediate.
//   * Computes the ALU result and the signed-overflow flag for ADD/SUB.
//   * Resolves BEQ/BNE. The branch compare always uses in_rs against in_rt.
//     The branch target is in_pc + (in_imm << BR_SHIFT).
//
// The stage holds one output entry. It has valid/ready handshakes toward
// decode (input side) and toward memory (output side).
//
// Optional feature: define EX_MULDIV_EN to add the iterative multiply/divide
// unit (MUL, DIVU, REMU).
//   * It works one bit per cycle and takes XLEN cycles per operation.
//   * The stage stalls (in_ready low) while it runs.
//   * Without the macro, funct 1101-1111 complete in one cycle with result 0.
//
// Parameters:
//   XLEN      datapath width (>= 8)
//   BR_SHIFT  left shift of the immediate when forming the branch offset
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   flush             drop the held output entry and abort any mul/div
//   in_valid/ready    decode handshake
//   in_pc             PC+4 of the instruction
//   in_rs, in_rt      register operands A and B
//   in_imm            sign-extended immediate
//   in_alusrc         1: operand B = in_imm, 0: operand B = in_rt
//   in_br_op          00 none, 01 BEQ, 10 BNE, 11 none
//   in_funct          ALU operation code
//   out_valid/ready   memory-stage handshake
//   out_result        ALU or mul/div result
//   out_zero          out_result == 0
//   out_overflow      signed overflow of ADD/SUB
//   out_br_taken      branch condition met
//   out_next_pc       branch target if taken, else in_pc
// ----------------------------------------------------------------------------
module ex_stage_pipe #(
  parameter int XLEN     = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs,
  input  logic [XLEN-1:0] in_rt,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_alusrc,
  input  logic [1:0]      in_br_op,
  input  logic [3:0]      in_funct,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic            out_overflow,
  output logic            out_br_taken,
  output logic [XLEN-1:0] out_next_pc
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] F_AND  = 4'b0000;
  localparam logic [3:0] F_OR   = 4'b0001;
  localparam logic [3:0] F_ADD  = 4'b0010;
  localparam logic [3:0] F_XOR  = 4'b0011;
  localparam logic [3:0] F_SUB  = 4'b0110;
  localparam logic [3:0] F_SLT  = 4'b0111;
  localparam logic [3:0] F_SLL  = 4'b1000;
  localparam logic [3:0] F_SRL  = 4'b1001;
  localparam logic [3:0] F_SRA  = 4'b1010;
  localparam logic [3:0] F_SLTU = 4'b1011;
  localparam logic [3:0] F_NOR  = 4'b1100;

  // --------------------------------------------------------------------------
  // Operand select and single-cycle ALU
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] op_b;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] add_sum;
  logic [XLEN-1:0] sub_diff;
  logic            add_ovf;
  logic            sub_ovf;
  logic [XLEN-1:0] alu_res;
  logic            alu_ovf;

  assign op_b     = in_alusrc ? in_imm : in_rt;
  assign shamt    = op_b[SHW-1:0];
  assign add_sum  = in_rs + op_b;
  assign sub_diff = in_rs - op_b;

  // ADD overflows when both operands have the same sign and the sum has the
  // other sign. SUB overflows when the operand signs differ and the result
  // sign differs from A.
  assign add_ovf = (in_rs[XLEN-1] == op_b[XLEN-1]) &&
                   (add_sum[XLEN-1] != in_rs[XLEN-1]);
  assign sub_ovf = (in_rs[XLEN-1] != op_b[XLEN-1]) &&
                   (sub_diff[XLEN-1] != in_rs[XLEN-1]);

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (in_funct)
      F_AND:  alu_res = in_rs & op_b;
      F_OR:   alu_res = in_rs | op_b;
      F_ADD: begin
        alu_res = add_sum;
        alu_ovf = add_ovf;
      end
      F_XOR:  alu_res = in_rs ^ op_b;
      F_SUB: begin
        alu_res = sub_diff;
        alu_ovf = sub_ovf;
      end
      F_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(in_rs) < $signed(op_b))};
      F_SLTU: alu_res = {{(XLEN-1){1'b0}}, (in_rs < op_b)};
      F_NOR:  alu_res = ~(in_rs | op_b);
      F_SLL:  alu_res = in_rs << shamt;
      F_SRL:  alu_res = in_rs >> shamt;
      F_SRA:  alu_res = $signed(in_rs) >>> shamt;
      // 0100, 0101 and the mul/div codes produce 0 on this path.
      default: alu_res = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Branch resolution (operand select is ignored: always rs vs rt)
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] rs_rt_diff;
  logic            rs_eq_rt;
  logic            br_taken;
  logic [XLEN-1:0] br_next_pc;

  for (genvar gi = 0; gi < XLEN; gi++) begin : g_br_cmp
    assign rs_rt_diff[gi] = in_rs[gi] ^ in_rt[gi];
  end

  assign rs_eq_rt   = ~|rs_rt_diff;
  assign br_taken   = ((in_br_op == 2'b01) &&  rs_eq_rt) ||
                      ((in_br_op == 2'b10) && !rs_eq_rt);
  assign br_next_pc = br_taken ? (in_pc + (in_imm << BR_SHIFT)) : in_pc;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic out_valid_reg;
  logic out_valid_next;
  logic run_state;
  logic accept;

  // Flush forces in_ready low, so a flush always wins over an accept in the
  // same cycle.
  assign in_ready = !rst && !flush && run_state && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;

  // Interface between the optional mul/div unit and the output register.
  logic            md_start;
  logic            md_done;
  logic [XLEN-1:0] md_result;
  logic            md_br_taken;
  logic [XLEN-1:0] md_next_pc;

`ifdef EX_MULDIV_EN
  // --------------------------------------------------------------------------
  // Iterative multiply / divide.
  //   md_a: multiplicand (shifts left) or divisor (fixed).
  //   md_b: multiplier (shifts right) or dividend shifting out while the
  //         quotient shifts in.
  //   md_acc: running product, or the partial remainder.
  // --------------------------------------------------------------------------
  localparam logic [3:0] F_MUL  = 4'b1101;
  localparam logic [3:0] F_DIVU = 4'b1110;
  localparam logic [3:0] F_REMU = 4'b1111;

  localparam logic [1:0] MD_MUL  = 2'd0;
  localparam logic [1:0] MD_DIVU = 2'd1;
  localparam logic [1:0] MD_REMU = 2'd2;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_MD  = 1'b1
  } state_t;

  state_t          state_reg,       state_next;
  logic [SHW-1:0]  cnt_reg,         cnt_next;
  logic [XLEN-1:0] md_a_reg,        md_a_next;
  logic [XLEN-1:0] md_b_reg,        md_b_next;
  logic [XLEN-1:0] md_acc_reg,      md_acc_next;
  logic [1:0]      md_op_reg,       md_op_next;
  logic            md_br_taken_reg, md_br_taken_next;
  logic [XLEN-1:0] md_next_pc_reg,  md_next_pc_next;

  logic            is_md;
  logic [XLEN-1:0] mul_acc_step;
  logic            div_top;
  logic [XLEN-1:0] div_low;
  logic [XLEN:0]   div_sub;
  logic            div_ok;
  logic [XLEN-1:0] div_rem_step;
  logic [XLEN-1:0] div_quo_step;

  assign is_md     = (in_funct == F_MUL) || (in_funct == F_DIVU) ||
                     (in_funct == F_REMU);
  assign md_start  = accept && is_md;
  assign run_state = (state_reg == ST_RUN);

  // Shift-add multiply step: add the multiplicand when the current
  // multiplier bit is set.
  assign mul_acc_step = md_acc_reg + (md_b_reg[0] ? md_a_reg : '0);

  // Restoring divide step. Shift the next dividend bit into the remainder,
  // giving an (XLEN+1)-bit value {div_top, div_low}. If div_top is set, that
  // value is at least 2^XLEN and already exceeds the divisor. Otherwise the
  // borrow of the low-part subtraction decides. With a zero divisor the
  // subtraction never borrows. The quotient then becomes all ones and the
  // remainder ends up equal to the dividend.
  assign div_top      = md_acc_reg[XLEN-1];
  assign div_low      = {md_acc_reg[XLEN-2:0], md_b_reg[XLEN-1]};
  assign div_sub      = {1'b0, div_low} - {1'b0, md_a_reg};
  assign div_ok       = div_top || !div_sub[XLEN];
  assign div_rem_step = div_ok ? div_sub[XLEN-1:0] : div_low;
  assign div_quo_step = {md_b_reg[XLEN-2:0], div_ok};

  always_comb begin
    case (md_op_reg)
      MD_MUL:  md_result = mul_acc_step;
      MD_DIVU: md_result = div_quo_step;
      MD_REMU: md_result = div_rem_step;
      default: md_result = '0;
    endcase
  end

  assign md_br_taken = md_br_taken_reg;
  assign md_next_pc  = md_next_pc_reg;

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    md_a_next        = md_a_reg;
    md_b_next        = md_b_reg;
    md_acc_next      = md_acc_reg;
    md_op_next       = md_op_reg;
    md_br_taken_next = md_br_taken_reg;
    md_next_pc_next  = md_next_pc_reg;
    md_done          = 1'b0;

    case (state_reg)
      ST_RUN: begin
        if (md_start) begin
          state_next       = ST_MD;
          cnt_next         = '0;
          md_a_next        = op_b;
          md_b_next        = in_rs;
          md_acc_next      = '0;
          md_br_taken_next = br_taken;
          md_next_pc_next  = br_next_pc;
          case (in_funct)
            F_MUL:   md_op_next = MD_MUL;
            F_DIVU:  md_op_next = MD_DIVU;
            default: md_op_next = MD_REMU;
          endcase
        end
      end
      ST_MD: begin
        if (md_op_reg == MD_MUL) begin
          md_acc_next = mul_acc_step;
          md_a_next   = md_a_reg << 1;
          md_b_next   = md_b_reg >> 1;
        end else begin
          md_acc_next = div_rem_step;
          md_b_next   = div_quo_step;
        end
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CNT_LAST) begin
          md_done    = 1'b1;
          state_next = ST_RUN;
          cnt_next   = '0;
        end
      end
      default: state_next = ST_RUN;
    endcase

    // Flush abandons the operation; the partial result is simply dropped.
    if (flush) begin
      state_next = ST_RUN;
      cnt_next   = '0;
      md_done    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_RUN;
      cnt_reg         <= '0;
      md_a_reg        <= '0;
      md_b_reg        <= '0;
      md_acc_reg      <= '0;
      md_op_reg       <= MD_MUL;
      md_br_taken_reg <= 1'b0;
      md_next_pc_reg  <= '0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      md_a_reg        <= md_a_next;
      md_b_reg        <= md_b_next;
      md_acc_reg      <= md_acc_next;
      md_op_reg       <= md_op_next;
      md_br_taken_reg <= md_br_taken_next;
      md_next_pc_reg  <= md_next_pc_next;
    end
  end
`else
  // No mul/div unit: every funct goes through the single-cycle path.
  assign run_state   = 1'b1;
  assign md_start    = 1'b0;
  assign md_done     = 1'b0;
  assign md_result   = '0;
  assign md_br_taken = 1'b0;
  assign md_next_pc  = '0;
`endif

  // --------------------------------------------------------------------------
  // Output register
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] out_result_reg,   out_result_next;
  logic            out_zero_reg,     out_zero_next;
  logic            out_overflow_reg, out_overflow_next;
  logic            out_br_taken_reg, out_br_taken_next;
  logic [XLEN-1:0] out_next_pc_reg,  out_next_pc_next;

  always_comb begin
    out_valid_next    = out_valid_reg;
    out_result_next   = out_result_reg;
    out_zero_next     = out_zero_reg;
    out_overflow_next = out_overflow_reg;
    out_br_taken_next = out_br_taken_reg;
    out_next_pc_next  = out_next_pc_reg;

    if (flush) begin
      out_valid_next = 1'b0;
    end else if (accept && !md_start) begin
      out_valid_next    = 1'b1;
      out_result_next   = alu_res;
      out_zero_next     = (alu_res == '0);
      out_overflow_next = alu_ovf;
      out_br_taken_next = br_taken;
      out_next_pc_next  = br_next_pc;
    end else if (md_start) begin
      // The accept implies any previous entry was consumed on this edge.
      out_valid_next = 1'b0;
    end else if (md_done) begin
      out_valid_next    = 1'b1;
      out_result_next   = md_result;
      out_zero_next     = (md_result == '0);
      out_overflow_next = 1'b0;
      out_br_taken_next = md_br_taken;
      out_next_pc_next  = md_next_pc;
    end else if (out_valid_reg && out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg    <= 1'b0;
      out_result_reg   <= '0;
      out_zero_reg     <= 1'b0;
      out_overflow_reg <= 1'b0;
      out_br_taken_reg <= 1'b0;
      out_next_pc_reg  <= '0;
    end else begin
      out_valid_reg    <= out_valid_next;
      out_result_reg   <= out_result_next;
      out_zero_reg     <= out_zero_next;
      out_overflow_reg <= out_overflow_next;
      out_br_taken_reg <= out_br_taken_next;
      out_next_pc_reg  <= out_next_pc_next;
    end
  end

  assign out_valid    = out_valid_reg;
  assign out_result   = out_result_reg;
  assign out_zero     = out_zero_reg;
  assign out_overflow = out_overflow_reg;
  assign out_br_taken = out_br_taken_reg;
  assign out_next_pc  = out_next_pc_reg;

endmodule

// File: tb/tb_ex_stage_pipe.sv
`timescale 1ns/1ps
module tb_ex_stage_pipe;

`ifdef EX_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_alusrc;
  logic [31:0] in_pc, in_rs, in_rt, in_imm;
  logic [1:0]  in_br_op;
  logic [3:0]  in_funct;
  logic        out_valid, out_ready, out_zero, out_overflow, out_br_taken;
  logic [31:0] out_result, out_next_pc;

  always #5 clk = ~clk;

  ex_stage_pipe #(.XLEN(32), .BR_SHIFT(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
    .in_alusrc(in_alusrc), .in_br_op(in_br_op), .in_funct(in_funct),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_overflow(out_overflow),
    .out_br_taken(out_br_taken), .out_next_pc(out_next_pc)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic        alusrc;
    logic [1:0]  br_op;
    logic [3:0]  funct;
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    logic        taken;
    logic [31:0] npc;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] pc, rs, rt, imm, input logic alusrc,
                              input logic [1:0] br, input logic [3:0] funct,
                              input logic [31:0] res, input logic z, ov, tk,
                              input logic [31:0] npc);
    vec_t v;
    v.pc = pc; v.rs = rs; v.rt = rt; v.imm = imm; v.alusrc = alusrc;
    v.br_op = br; v.funct = funct; v.res = res; v.zero = z; v.ovf = ov;
    v.taken = tk; v.npc = npc;
    return v;
  endfunction

  // Reference model: plain integer arithmetic on the instruction semantics.
  function automatic vec_t ref_model(input vec_t v);
    vec_t        r;
    logic [31:0] b;
    longint      sa, sb, s;
    logic [63:0] p;
    r = v;
    b = v.alusrc ? v.imm : v.rt;
    sa = longint'($signed(v.rs));
    sb = longint'($signed(b));
    r.ovf = 1'b0;
    r.res = 32'd0;
    case (v.funct)
      4'd0:  r.res = v.rs & b;
      4'd1:  r.res = v.rs | b;
      4'd2: begin
        s = sa + sb; r.res = s[31:0];
        r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd3:  r.res = v.rs ^ b;
      4'd6: begin
        s = sa - sb; r.res = s[31:0];
        r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd7:  r.res = (sa < sb) ? 32'd1 : 32'd0;
      4'd11: r.res = (v.rs < b) ? 32'd1 : 32'd0;
      4'd12: r.res = ~(v.rs | b);
      4'd8:  r.res = v.rs << b[4:0];
      4'd9:  r.res = v.rs >> b[4:0];
      4'd10: r.res = 32'(sa >>> b[4:0]);
      4'd13: begin p = 64'(v.rs) * 64'(b); r.res = MD_EN ? p[31:0] : 32'd0; end
      4'd14: r.res = !MD_EN ? 32'd0 : (b == 0) ? 32'hFFFF_FFFF : v.rs / b;
      4'd15: r.res = !MD_EN ? 32'd0 : (b == 0) ? v.rs : v.rs % b;
      default: r.res = 32'd0;
    endcase
    r.zero  = (r.res == 32'd0);
    r.taken = (v.br_op == 2'b01 && v.rs == v.rt) || (v.br_op == 2'b10 && v.rs != v.rt);
    r.npc   = r.taken ? v.pc + v.imm * 32'd4 : v.pc;
    return r;
  endfunction

  task automatic apply(input vec_t v);
    in_pc = v.pc; in_rs = v.rs; in_rt = v.rt; in_imm = v.imm;
    in_alusrc = v.alusrc; in_br_op = v.br_op; in_funct = v.funct;
  endtask

  // Issue one instruction (called just after a falling edge), wait for its
  // result with a bounded wait, and compare every output field.
  task automatic run_txn(input vec_t v, input string tag);
    int lat, guard, busy_bad, exp_lat;
    exp_lat = (MD_EN && v.funct >= 4'd13) ? 33 : 1;
    apply(v);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk); #1; guard++;
    end
    check($sformatf("%s.accept", tag), 32'(in_ready), 32'd1);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 1;
    busy_bad = 0;
    while (!out_valid && lat < 60) begin
      if (in_ready) busy_bad++;
      @(negedge clk);
      lat++;
    end
    n_txn++;
    $display("txn %0d %s funct=%h rs=%h b=%h result=%h lat=%0d",
             n_txn, tag, v.funct, v.rs, v.alusrc ? v.imm : v.rt, out_result, lat);
    check($sformatf("%s.latency", tag), 32'(lat), 32'(exp_lat));
    check($sformatf("%s.busy_ready", tag), 32'(busy_bad), 32'd0);
    check($sformatf("%s.result", tag), out_result, v.res);
    check($sformatf("%s.zero", tag), 32'(out_zero), 32'(v.zero));
    check($sformatf("%s.ovf", tag), 32'(out_overflow), 32'(v.ovf));
    check($sformatf("%s.taken", tag), 32'(out_br_taken), 32'(v.taken));
    check($sformatf("%s.next_pc", tag), out_next_pc, v.npc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  vec_t tbl[$];
  vec_t v, v2;
  int   seen;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_rs = '0; in_rt = '0; in_imm = '0;
    in_alusrc = 1'b0; in_br_op = 2'b00; in_funct = 4'd0;

    // Expected-value table: pc, rs, rt, imm, alusrc, br, funct -> res, z, ov, taken, npc
    tbl.push_back(mk(32'h40, 32'h7FFF_FFFF, 32'h1, 32'h0, 0, 2'b00, 4'd2, 32'h8000_0000, 0, 1, 0, 32'h40));
    tbl.push_back(mk(32'h44, 32'h5, 32'h5, 32'h0, 0, 2'b00, 4'd6, 32'h0, 1, 0, 0, 32'h44));
    tbl.push_back(mk(32'h100, 32'h3, 32'h3, 32'hFFFF_FFFE, 0, 2'b01, 4'd6, 32'h0, 1, 0, 1, 32'hF8));
    tbl.push_back(mk(32'h100, 32'h3, 32'h3, 32'hFFFF_FFFE, 0, 2'b10, 4'd6, 32'h0, 1, 0, 0, 32'h100));
    tbl.push_back(mk(32'h8, 32'hF0F0_F0F0, 32'h0, 32'h0FF0_0FF0, 1, 2'b00, 4'd0, 32'h00F0_00F0, 0, 0, 0, 32'h8));
    tbl.push_back(mk(32'h8, 32'h0, 32'h0, 32'h0, 0, 2'b00, 4'd12, 32'hFFFF_FFFF, 0, 0, 0, 32'h8));
    tbl.push_back(mk(32'h8, 32'hFFFF_FFFF, 32'h1, 32'h0, 0, 2'b00, 4'd7, 32'h1, 0, 0, 0, 32'h8));
    tbl.push_back(mk(32'h8, 32'hFFFF_FFFF, 32'h1, 32'h0, 0, 2'b00, 4'd11, 32'h0, 1, 0, 0, 32'h8));
    tbl.push_back(mk(32'h8, 32'h8000_0000, 32'h0, 32'h24, 1, 2'b00, 4'd10, 32'hF800_0000, 0, 0, 0, 32'h8));
    tbl.push_back(mk(32'h8, 32'h8000_0000, 32'd31, 32'h0, 0, 2'b00, 4'd9, 32'h1, 0, 0, 0, 32'h8));
    tbl.push_back(mk(32'h8, 32'h3, 32'h4, 32'h0, 0, 2'b00, 4'd8, 32'h30, 0, 0, 0, 32'h8));
    tbl.push_back(mk(32'h8, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h0, 0, 2'b00, 4'd3, 32'h5A5A_5A5A, 0, 0, 0, 32'h8));
    tbl.push_back(mk(32'h8, 32'h8000_0000, 32'h1, 32'h0, 0, 2'b00, 4'd6, 32'h7FFF_FFFF, 0, 1, 0, 32'h8));
    tbl.push_back(mk(32'h8, 32'h5, 32'h6, 32'h0, 0, 2'b00, 4'd4, 32'h0, 1, 0, 0, 32'h8));
    tbl.push_back(mk(32'h20, 32'h1, 32'h2, 32'h7, 0, 2'b11, 4'd1, 32'h3, 0, 0, 0, 32'h20));
    tbl.push_back(mk(32'h8, 32'h10, 32'h0, 32'hFFFF_FFFF, 1, 2'b00, 4'd2, 32'hF, 0, 0, 0, 32'h8));
    tbl.push_back(mk(32'h8, 32'hFFFF, 32'h1_0001, 32'h0, 0, 2'b00, 4'd13,
                     MD_EN ? 32'hFFFF_FFFF : 32'h0, !MD_EN, 0, 0, 32'h8));
    tbl.push_back(mk(32'h8, 32'h7, 32'h0, 32'h0, 0, 2'b00, 4'd14,
                     MD_EN ? 32'hFFFF_FFFF : 32'h0, !MD_EN, 0, 0, 32'h8));
    tbl.push_back(mk(32'h8, 32'h7, 32'h0, 32'h0, 0, 2'b00, 4'd15,
                     MD_EN ? 32'h7 : 32'h0, !MD_EN, 0, 0, 32'h8));
    tbl.push_back(mk(32'h200, 32'd100, 32'd7, 32'h4, 0, 2'b10, 4'd14,
                     MD_EN ? 32'hE : 32'h0, !MD_EN, 0, 1, 32'h210));
    tbl.push_back(mk(32'h200, 32'd100, 32'd7, 32'h4, 0, 2'b00, 4'd15,
                     MD_EN ? 32'h2 : 32'h0, !MD_EN, 0, 0, 32'h200));
    tbl.push_back(mk(32'h1000, 32'h1234_5678, 32'h1234_5678, 32'h10, 1, 2'b01, 4'd13,
                     MD_EN ? 32'h2345_6780 : 32'h0, !MD_EN, 0, 1, 32'h1040));

    // ---- Reset: two cycles, then release ----
    @(posedge clk); @(posedge clk); @(negedge clk); #1;
    check("reset.in_ready", 32'(in_ready), 32'd0);
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.result", out_result, 32'd0);
    check("reset.zero", 32'(out_zero), 32'd0);
    check("reset.ovf", 32'(out_overflow), 32'd0);
    check("reset.taken", 32'(out_br_taken), 32'd0);
    check("reset.next_pc", out_next_pc, 32'd0);
    rst = 1'b0; #1;
    check("reset.release_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // ---- Table ----
    for (int i = 0; i < tbl.size(); i++) begin
      run_txn(tbl[i], $sformatf("tbl%0d", i));
      @(negedge clk);
    end

    // ---- Back-to-back ADD then SUB at full throughput ----
    apply(tbl[0]); in_valid = 1'b1; out_ready = 1'b1; #1;
    check("b2b.ready0", 32'(in_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    apply(tbl[1]); #1;
    check("b2b.ready1", 32'(in_ready), 32'd1);
    check("b2b.valid0", 32'(out_valid), 32'd1);
    check("b2b.result0", out_result, 32'h8000_0000);
    check("b2b.ovf0", 32'(out_overflow), 32'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; #1;
    check("b2b.valid1", 32'(out_valid), 32'd1);
    check("b2b.result1", out_result, 32'd0);
    check("b2b.zero1", 32'(out_zero), 32'd1);
    check("b2b.ovf1", 32'(out_overflow), 32'd0);
    @(posedge clk); @(negedge clk); #1;
    check("b2b.drained", 32'(out_valid), 32'd0);
    $display("txn seq back-to-back add/sub done");

    // ---- Backpressure on an OR, then consume + accept on one edge ----
    @(negedge clk);
    apply(mk(32'h8, 32'hF0, 32'h0F, 32'h0, 0, 2'b00, 4'd1, 0, 0, 0, 0, 0));
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    apply(mk(32'h8, 32'hFF, 32'h0F, 32'h0, 0, 2'b00, 4'd3, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp.valid%0d", k), 32'(out_valid), 32'd1);
      check($sformatf("bp.result%0d", k), out_result, 32'hFF);
      check($sformatf("bp.ready%0d", k), 32'(in_ready), 32'd0);
      @(posedge clk); @(negedge clk);
    end
    out_ready = 1'b1; #1;
    check("bp.release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; #1;
    check("bp.next_valid", 32'(out_valid), 32'd1);
    check("bp.next_result", out_result, 32'hF0);
    @(posedge clk); @(negedge clk);
    $display("txn seq backpressure done");

    // ---- Flush drops the held entry and blocks a same-cycle accept ----
    apply(tbl[4]); in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b1; flush = 1'b1; #1;
    check("flush.held_valid", 32'(out_valid), 32'd1);
    check("flush.ready", 32'(in_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; #1;
    check("flush.cleared", 32'(out_valid), 32'd0);
    check("flush.ready_after", 32'(in_ready), 32'd1);
    @(negedge clk);
    $display("txn seq flush of held output done");

`ifdef EX_MULDIV_EN
    // ---- Flush at iteration 10 of DIVU ----
    apply(tbl[19]); in_valid = 1'b1; out_ready = 1'b1; #1;
    check("mdflush.accept", 32'(in_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k < 10; k++) @(negedge clk);
    flush = 1'b1; #1;
    check("mdflush.ready_during", 32'(in_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    flush = 1'b0; #1;
    check("mdflush.ready_after", 32'(in_ready), 32'd1);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    check("mdflush.no_result", 32'(seen), 32'd0);
    run_txn(tbl[0], "mdflush.add");
    @(negedge clk);

    // ---- Reset in the middle of a MUL ----
    apply(tbl[16]); in_valid = 1'b1; #1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) @(negedge clk);
    rst = 1'b1; #1;
    check("mdrst.ready_in_reset", 32'(in_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0; #1;
    check("mdrst.ready_after", 32'(in_ready), 32'd1);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    check("mdrst.no_result", 32'(seen), 32'd0);
    $display("txn seq mul/div flush and reset done");
`endif

    // ---- Randomised instructions against the reference model ----
    for (int i = 0; i < 200; i++) begin
      logic [15:0] h;
      v.funct  = 4'($urandom_range(0, 15));
      v.rs     = $urandom;
      v.rt     = ($urandom_range(0, 3) == 0) ? v.rs : $urandom;
      if ($urandom_range(0, 4) == 0) v.rt = $urandom_range(0, 15);
      h        = 16'($urandom);
      v.imm    = $urandom_range(0, 1) ? $urandom : {{16{h[15]}}, h};
      if ($urandom_range(0, 5) == 0) v.imm = $urandom_range(0, 3);
      v.alusrc = 1'($urandom_range(0, 1));
      v.br_op  = 2'($urandom_range(0, 3));
      v.pc     = $urandom & 32'hFFFF_FFFC;
      v2 = ref_model(v);
      run_txn(v2, $sformatf("rnd%0d", i));
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage_pipe.md
# ex_stage_pipe

Parametrised, registered execute stage for the pipelined MIPS core: selects ALU operand B (register or sign-extended immediate), computes the ALU result, and resolves BEQ/BNE branches to a next-PC. Sits between decode and memory with valid/ready handshakes on both sides, a flush input, and an optional iterative multiply/divide unit that stalls the stage while it runs.

## Interface
- XLEN, 32: datapath width; ≥ 8.
- BR_SHIFT, 2: left shift applied to the immediate to form the branch offset.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard held output and abort any in-flight operation.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_pc  in  XLEN  PC+4 of the instruction.
- in_rs, in_rt  in  XLEN  register operands A and B.
- in_imm  in  XLEN  sign-extended immediate.
- in_alusrc  in  1  1: B = in_imm; 0: B = in_rt.
- in_br_op  in  2  00 none, 01 BEQ, 10 BNE, 11 treated as none.
- in_funct  in  4  ALU operation code.
- out_valid  out  1  result register holds a valid entry.
- out_ready  in  1  memory stage consumes the entry.
- out_result  out  XLEN  ALU / mul-div result.
- out_zero  out  1  out_result == 0.
- out_overflow  out  1  signed overflow on ADD/SUB.
- out_br_taken  out  1  branch condition met.
- out_next_pc  out  XLEN  branch target if taken, else in_pc.

## Operation
- funct: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB, 0111 SLT (signed), 1011 SLTU, 1100 NOR, 1000 SLL, 1001 SRL, 1010 SRA (amount = B[$clog2(XLEN)-1:0]), 1101 MUL (low XLEN bits), 1110 DIVU quotient, 1111 REMU; 0100/0101 give result 0.
- Branch compare always in_rs vs in_rt (ignores in_alusrc): BEQ taken if equal, BNE if unequal.
- Target = in_pc + (in_imm << BR_SHIFT), modulo 2^XLEN; wrap-around ignored.
- out_overflow set only for ADD/SUB signed overflow; 0 otherwise.
- Handshake: transfer on in_valid && in_ready; output consumed on out_valid && out_ready.
- FSM: ST_RUN (single-cycle ops flow) and ST_MD (iterating). Accepting funct 1101–1111 enters ST_MD, loads operands, clears counter; one bit per cycle (shift-add multiply, restoring divide), XLEN iterations, then writes output register, sets out_valid, returns to ST_RUN.
- in_ready = !rst && state==ST_RUN && (!out_valid || out_ready).
- DIVU by zero: quotient all-ones, REMU returns dividend; still XLEN cycles.
- Flush: clears out_valid and, in ST_MD, returns to ST_RUN discarding partial result; in_ready held 0 during flush, so flush wins over a same-cycle accept.

## Timing
- Reset: out_valid 0, out_result 0, out_zero 0, out_overflow 0, out_br_taken 0, out_next_pc 0, state ST_RUN, counter 0; in_ready 0 while rst high, 1 the following cycle.
- Single-cycle ops: accepted at edge N, out_valid high after edge N; full throughput, one per cycle with out_ready held 1.
- Mul/div: accepted at edge N, out_valid high after edge N+XLEN; in_ready 0 through that interval.
- Backpressure: out_valid && !out_ready holds all outputs stable and in_ready 0.
- Simultaneous consume + accept: old entry leaves and new entry loads on the same edge.
- Reset mid-iteration: FSM to ST_RUN, partial result discarded.

## Configuration
- EX_MULDIV_EN defined: mul/div datapath, counter and ST_MD present as above.
- Undefined: no ST_MD, no mul/div logic; funct 1101–1111 complete in one cycle with out_result 0, out_overflow 0; branch fields still computed.

## Test plan
- Reset: rst 2 cycles → all outputs 0, in_ready 0; cycle after release → in_ready 1.
- ADD 0x7FFFFFFF + 1 (alusrc 0), then SUB 5−5 back-to-back with out_ready 1 → results 0x80000000 overflow 1, then 0 zero 1, on consecutive cycles.
- BEQ rs=rt=3, pc 0x100, imm 0xFFFFFFFE → br_taken 1, next_pc 0xF8; BNE same operands → br_taken 0, next_pc 0x100.
- MUL 0xFFFF×0x10001 (MULDIV_EN) → in_ready 0 for 32 cycles, result 0xFFFFFFFF; DIVU 7/0 → 0xFFFFFFFF; REMU 7/0 → 7.
- Hold out_ready 0 for 3 cycles after an OR → outputs stable, in_ready 0; release with next instruction present → consume and accept same edge.
- Flush at iteration 10 of DIVU → out_valid stays 0, in_ready 1 next cycle, following ADD completes normally.
